// File: rtl/mbssoc_mem_responder_pkg.sv
// Shared constants for the memory responder: FSM encodings and wait-counter sizing.
package mbssoc_mem_responder_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] MEM_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] MEM_WAIT = 2'd1;
  localparam logic [STATE_W-1:0] MEM_DONE = 2'd2;

  localparam int DEFAULT_WAIT_CYCLES = 1;

  // The wait counter covers the full 0..15 range of programmable wait states.
  localparam int                    WAIT_CNT_W = 4;
  localparam logic [WAIT_CNT_W-1:0] CNT_ONE    = 4'd1;

endpackage

// File: rtl/mbssoc_mem_array.sv
// Single-port word array with synchronous write and registered synchronous read.
module mbssoc_mem_array #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic                  rd_clr,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [0:(1<<DEPTH_LOG2)-1];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= wdata;
    end
  end

  // The read register holds its value between reads; rd_clr forces a zero word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= rd_clr ? '0 : mem[addr];
    end
  end

endmodule

// File: rtl/mbssoc_mem_responder.sv
// Target end of the arbitrated RAM port: captures one request, waits, then completes it.
module mbssoc_mem_responder
  import mbssoc_mem_responder_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ram_re,
  input  logic                  ram_we,
  input  logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic                  cpu_sel,
  output logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  rdata_valid,
  output logic                  ack,
  output logic                  resp_core,
  output logic                  ram_busy,
  output logic                  addr_err
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_CYCLES);

  logic [STATE_W-1:0]    state;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic [DEPTH_LOG2-1:0] cap_idx;
  logic [DATA_WIDTH-1:0] cap_wdata;
  logic                  cap_write;
  logic                  cap_read;
  logic                  cap_core;
  logic                  cap_oor;

  logic out_of_range;
  logic in_done;
  logic unused_addr_bits;

  // Byte-lane bits are meaningless for word accesses.
  assign unused_addr_bits = ^ram_addr[1:0];
  assign out_of_range     = |ram_addr[ADDR_WIDTH-1:DEPTH_LOG2+2];
  assign in_done          = (state == MEM_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= MEM_IDLE;
      wait_cnt    <= '0;
      cap_idx     <= '0;
      cap_wdata   <= '0;
      cap_write   <= 1'b0;
      cap_read    <= 1'b0;
      cap_core    <= 1'b0;
      cap_oor     <= 1'b0;
      rdata_valid <= 1'b0;
      ack         <= 1'b0;
      resp_core   <= 1'b0;
      ram_busy    <= 1'b0;
      addr_err    <= 1'b0;
    end else begin
      ack         <= 1'b0;
      rdata_valid <= 1'b0;
      addr_err    <= 1'b0;
      case (state)
        MEM_IDLE: begin
          if (ram_re || ram_we) begin
            // A combined read+write request is treated as a plain write.
            cap_idx   <= ram_addr[DEPTH_LOG2+1:2];
            cap_wdata <= ram_wdata;
            cap_write <= ram_we;
            cap_read  <= ram_re && !ram_we;
            cap_core  <= cpu_sel;
            cap_oor   <= out_of_range;
            ram_busy  <= 1'b1;
            wait_cnt  <= WAIT_INIT;
            state     <= (WAIT_CYCLES > 0) ? MEM_WAIT : MEM_DONE;
          end
        end
        MEM_WAIT: begin
          wait_cnt <= wait_cnt - CNT_ONE;
          if (wait_cnt == CNT_ONE) begin
            state <= MEM_DONE;
          end
        end
        MEM_DONE: begin
          ack         <= 1'b1;
          resp_core   <= cap_core;
          rdata_valid <= cap_read;
          addr_err    <= cap_oor;
          ram_busy    <= 1'b0;
          state       <= MEM_IDLE;
        end
        default: begin
          state <= MEM_IDLE;
        end
      endcase
    end
  end

  mbssoc_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (in_done && cap_write && !cap_oor),
    .rd_en  (in_done && cap_read),
    .rd_clr (cap_oor),
    .addr   (cap_idx),
    .wdata  (cap_wdata),
    .rdata  (ram_rdata)
  );

endmodule

// File: tb/tb_mbssoc_mem_responder.sv
// Randomised and directed bench for the memory responder against a word-level model.
module tb_mbssoc_mem_responder;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int DL = 10;
  localparam int WC = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ram_re = 1'b0;
  logic          ram_we = 1'b0;
  logic [AW-1:0] ram_addr = '0;
  logic [DW-1:0] ram_wdata = '0;
  logic          cpu_sel = 1'b0;
  logic [DW-1:0] ram_rdata;
  logic          rdata_valid;
  logic          ack;
  logic          resp_core;
  logic          ram_busy;
  logic          addr_err;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] model_mem [int];

  mbssoc_mem_responder #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .DEPTH_LOG2  (DL),
    .WAIT_CYCLES (WC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ram_re      (ram_re),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .cpu_sel     (cpu_sel),
    .ram_rdata   (ram_rdata),
    .rdata_valid (rdata_valid),
    .ack         (ack),
    .resp_core   (resp_core),
    .ram_busy    (ram_busy),
    .addr_err    (addr_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // One complete transaction: present, get accepted, wait for ack, compare with the model.
  task automatic applyStimulus(input logic re, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic core);
    logic          in_range;
    int            idx;
    logic          is_read;
    logic          data_known;
    logic [31:0]   exp_data;
    int            lat;
    in_range   = (addr[31:DL+2] == '0);
    idx        = int'(addr[DL+1:2]);
    is_read    = re && !we;
    data_known = 1'b1;
    exp_data   = '0;
    if (in_range) begin
      if (model_mem.exists(idx)) exp_data = model_mem[idx];
      else data_known = 1'b0;
    end
    @(negedge clk);
    checkOutput("busy_before", ram_busy, 1'b0);
    ram_re    = re;
    ram_we    = we;
    ram_addr  = addr;
    ram_wdata = wdata;
    cpu_sel   = core;
    @(negedge clk);
    ram_re    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = $urandom;
    ram_wdata = $urandom;
    cpu_sel   = 1'($urandom_range(0, 1));
    lat = 0;
    while (!ack && lat < 40) begin
      checkOutput("busy_wait", ram_busy, 1'b1);
      @(negedge clk);
      lat++;
    end
    if (!ack) begin
      checkOutput("ack_timeout", 1'b0, 1'b1);
    end else begin
      checkOutput("latency", lat, 1 + WC);
      checkOutput("rdata_valid", rdata_valid, is_read);
      checkOutput("resp_core", resp_core, core);
      checkOutput("addr_err", addr_err, !in_range);
      checkOutput("busy_at_ack", ram_busy, 1'b0);
      if (is_read && data_known) checkOutput("rdata", ram_rdata, exp_data);
      if (we && in_range) model_mem[idx] = wdata;
      @(negedge clk);
      checkOutput("ack_pulse", {ack, rdata_valid, addr_err}, 3'b000);
    end
  endtask

  initial begin
    int acks;
    int first_ack;
    int second_ack;
    logic        r_re;
    logic        r_we;
    logic [31:0] r_addr;
    int          r;

    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_flags", {rdata_valid, ack, resp_core, ram_busy, addr_err}, 5'b0);
    checkOutput("reset_rdata", ram_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("idle_flags", {rdata_valid, ack, resp_core, ram_busy, addr_err}, 5'b0);
      checkOutput("idle_rdata", ram_rdata, 32'h0);
    end

    $display("[TB] basic write/read");
    applyStimulus(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 1'b1);

    $display("[TB] request held while busy");
    @(negedge clk);
    ram_we = 1'b1; ram_re = 1'b0; ram_addr = 32'h14; ram_wdata = 32'hCAFEF00D; cpu_sel = 1'b0;
    acks = 0; first_ack = -1; second_ack = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ack) begin
        acks++;
        if (acks == 1) begin
          first_ack = c;
          model_mem[5] = 32'hCAFEF00D;
          ram_we = 1'b0; ram_re = 1'b1; cpu_sel = 1'b1;
        end else if (acks == 2) begin
          second_ack = c;
          checkOutput("b2b_rdata", ram_rdata, 32'hCAFEF00D);
          checkOutput("b2b_core", resp_core, 1'b1);
          ram_re = 1'b0;
        end
      end
    end
    checkOutput("b2b_ack_count", acks, 2);
    checkOutput("b2b_first", first_ack, 1 + WC);
    checkOutput("b2b_gap", second_ack - first_ack, 2 + WC);

    $display("[TB] out-of-range accesses");
    applyStimulus(1'b0, 1'b1, 32'h0, 32'h0BADF00D, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h1000, 32'hFFFFFFFF, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h1000, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b1);

    $display("[TB] simultaneous read and write");
    applyStimulus(1'b1, 1'b1, 32'h20, 32'h12345678, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);

    $display("[TB] reset during wait");
    applyStimulus(1'b0, 1'b1, 32'h30, 32'hA5A5A5A5, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h30, 32'h0, 1'b1);
    @(negedge clk);
    ram_we = 1'b1; ram_addr = 32'h30; ram_wdata = 32'h11111111; cpu_sel = 1'b1;
    @(negedge clk);
    ram_we = 1'b0;
    checkOutput("rst_busy_pre", ram_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_flags", {rdata_valid, ack, resp_core, ram_busy, addr_err}, 5'b0);
    checkOutput("rst_rdata", ram_rdata, 32'h0);
    repeat (2) begin
      @(negedge clk);
      checkOutput("rst_no_ack", ack, 1'b0);
    end
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h30, 32'h0, 1'b0);

    $display("[TB] random traffic");
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      r_re = (r < 4) || (r >= 8);
      r_we = (r >= 4);
      if ($urandom_range(0, 7) == 0) r_addr = $urandom | 32'h1000;
      else r_addr = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      applyStimulus(r_re, r_we, r_addr, $urandom, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
